uart_fpu_sequencer: RTL
=======================

// Module: uart_fpu_sequencer
// PURPOSE
//  Frame controller between the UART byte link and the floating-point unit.
//  Collects one opcode byte and two 32-bit operands (A, B) from UART RX, then starts the FPU.
//  Waits for the FPU result and returns it as 4 bytes on UART TX.
//  Supersedes the simple operand-received detect: it sequences the whole request/response transaction.
// PARAMETERS
//  DATA_W       32      operand/result width; must be a multiple of BYTE_W
//  BYTE_W       8       UART byte width
//  TIMEOUT_CYC  100000  inter-byte timeout in clocks (used only when UART_FPU_TIMEOUT_EN is defined)
// PORTS
//  i_clk         in   1        system clock, rising edge
//  i_rst_n       in   1        asynchronous reset, active low
//  i_rx_valid    in   1        one-cycle pulse: i_rx_data holds a received byte
//  i_rx_data     in   BYTE_W   received byte
//  i_tx_busy     in   1        UART TX is transmitting; goes high the cycle after o_tx_start
//  o_tx_start    out  1        one-cycle pulse: send o_tx_data
//  o_tx_data     out  BYTE_W   byte to transmit; valid with o_tx_start
//  o_fpu_op      out  2        FPU opcode (00 add, 01 sub, 10 mul, 11 div)
//  o_fpu_a       out  DATA_W   operand A
//  o_fpu_b       out  DATA_W   operand B
//  o_fpu_start   out  1        one-cycle FPU start pulse
//  i_fpu_done    in   1        one-cycle pulse: i_fpu_result is valid
//  i_fpu_result  in   DATA_W   FPU result
//  o_busy        out  1        high in every state except IDLE
//  o_done        out  1        one-cycle pulse after the last result byte is handed to TX
//  o_err         out  1        one-cycle pulse: bad opcode, overrun, or timeout
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; operand, result and byte-count registers 0. All outputs are registered.
//  Reset asserted mid-transaction aborts immediately. No partial frame or result survives it.
//  Byte order: MSB first for both RX operands and TX result.
//  NB = DATA_W/BYTE_W bytes per word (4 at default parameters).
//  States:
//   IDLE    On i_rx_valid: if i_rx_data[7:2] != 0, pulse o_err and stay in IDLE (byte dropped).
//           Otherwise o_fpu_op <= i_rx_data[1:0], cnt <= 0, go to RX_A.
//   RX_A    On i_rx_valid: A <= {A[DATA_W-BYTE_W-1:0], byte}, cnt++. When cnt reaches NB-1 with a valid byte: cnt <= 0, go to RX_B.
//   RX_B    Same shift into B. On the NB-th byte, go to START.
//   START   o_fpu_start = 1 for exactly one cycle, i.e. the cycle after the last B byte's i_rx_valid. Go to WAIT.
//   WAIT    On i_fpu_done: R <= i_fpu_result, cnt <= 0, go to TX_REQ.
//           i_fpu_done in any other state is ignored.
//   TX_REQ  When i_tx_busy == 0: o_tx_start = 1 for one cycle, o_tx_data <= R[DATA_W-1 -: BYTE_W], R <<= BYTE_W, cnt++. Go to TX_GAP.
//   TX_GAP  Hold one cycle so TX can raise busy. If cnt == NB go to FIN, else go to TX_REQ.
//   FIN     o_done = 1 for one cycle. Go to IDLE.
//  o_fpu_a, o_fpu_b and o_fpu_op are stable from START until the next frame's opcode is accepted.
//  Overrun: i_rx_valid in START, WAIT, TX_REQ, TX_GAP or FIN pulses o_err. The byte is dropped and the transaction continues.
//  i_rx_valid and the completing i_fpu_done in the same WAIT cycle: the result is latched and o_err pulses.
//  Minimum latency from last B byte to first o_tx_start is 2 + FPU latency + 1 cycles (i_tx_busy low).
// CONFIGURATION
//  UART_FPU_TIMEOUT_EN defined:
//   In RX_A/RX_B an idle counter clears on every i_rx_valid and increments otherwise.
//   When it reaches TIMEOUT_CYC-1: o_err pulses, the partial frame is discarded, state returns to IDLE.
//   The counter is held at 0 in all other states.
//  UART_FPU_TIMEOUT_EN undefined: no counter; RX_A/RX_B wait for bytes indefinitely.
// TESTING
//  Frame 00,3F,80,00,00,40,00,00,00 -> o_fpu_op=00, A=3F800000, B=40000000, single o_fpu_start one cycle after last byte.
//  FPU model returns 40400000 after 5 cycles, TX model busy 10 cycles per byte -> TX bytes 40,40,00,00 in order, then one o_done, o_busy=0.
//  Opcode byte 0x07 in IDLE -> o_err pulse, state stays IDLE; the following valid frame completes normally.
//  Extra rx byte during WAIT -> o_err pulse; result is still sent unchanged.
//  Reset pulse after the 3rd A byte -> all outputs 0; a new full frame completes with the correct operands.
//  With UART_FPU_TIMEOUT_EN, TIMEOUT_CYC=16: stall 20 cycles after 2 A bytes -> o_err pulse at cycle 16, state returns to IDLE.

Source files
------------

// File: rtl/uart_fpu_sequencer.sv
// UART <-> FPU frame sequencer: opcode + A + B in, 4-byte result out.
// Optional inter-byte timeout: define UART_FPU_TIMEOUT_EN.
module uart_fpu_sequencer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BYTE_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_valid,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_tx_busy,
  output logic              o_tx_start,
  output logic [BYTE_W-1:0] o_tx_data,
  output logic [1:0]        o_fpu_op,
  output logic [DATA_W-1:0] o_fpu_a,
  output logic [DATA_W-1:0] o_fpu_b,
  output logic              o_fpu_start,
  input  logic              i_fpu_done,
  input  logic [DATA_W-1:0] i_fpu_result,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned NB = DATA_W / BYTE_W;
  localparam int unsigned CW = $clog2(NB + 1);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);
  localparam logic [CW-1:0] FULL = CW'(NB);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RX_A   = 3'd1;
  localparam logic [2:0] RX_B   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] TX_REQ = 3'd5;
  localparam logic [2:0] TX_GAP = 3'd6;
  localparam logic [2:0] FIN    = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic [1:0]        op_q, op_d;
  logic [BYTE_W-1:0] txd_q, txd_d;
  logic              txs_q, txs_d;
  logic              fst_q, fst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q;
  logic              to_hit;

`ifdef UART_FPU_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYC);
  logic [IW-1:0] idle_q, idle_d;
  logic          in_rx;

  assign in_rx  = (state_q == RX_A) || (state_q == RX_B);
  assign to_hit = in_rx && !i_rx_valid &&
                  (idle_q == IW'(TIMEOUT_CYC - 2));
  assign idle_d = (in_rx && !i_rx_valid && !to_hit) ?
                  idle_q + 1'b1 : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) idle_q <= '0;
    else          idle_q <= idle_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    op_d    = op_q;
    txd_d   = txd_q;
    txs_d   = 1'b0;
    fst_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (|i_rx_data[BYTE_W-1:2]) begin
            err_d = 1'b1;
          end else begin
            op_d    = i_rx_data[1:0];
            cnt_d   = '0;
            state_d = RX_A;
          end
        end
      end
      RX_A: begin
        if (i_rx_valid) begin
          a_d = {a_q[DATA_W-BYTE_W-1:0], i_rx_data};
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = RX_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_B: begin
        if (i_rx_valid) begin
          b_d = {b_q[DATA_W-BYTE_W-1:0], i_rx_data};
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: begin
        err_d   = i_rx_valid;
        state_d = WAIT;
      end
      WAIT: begin
        err_d = i_rx_valid;
        if (i_fpu_done) begin
          r_d     = i_fpu_result;
          cnt_d   = '0;
          state_d = TX_REQ;
        end
      end
      TX_REQ: begin
        err_d = i_rx_valid;
        if (!i_tx_busy) begin
          txs_d   = 1'b1;
          txd_d   = r_q[DATA_W-1 -: BYTE_W];
          r_d     = r_q << BYTE_W;
          cnt_d   = cnt_q + 1'b1;
          state_d = TX_GAP;
        end
      end
      TX_GAP: begin
        err_d   = i_rx_valid;
        state_d = (cnt_q == FULL) ? FIN : TX_REQ;
      end
      FIN: begin
        err_d   = i_rx_valid;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Stalled partial frame is thrown away
    if (to_hit) begin
      err_d   = 1'b1;
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end
    fst_d  = (state_d == START);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= '0;
      txd_q   <= '0;
      txs_q   <= 1'b0;
      fst_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      op_q    <= op_d;
      txd_q   <= txd_d;
      txs_q   <= txs_d;
      fst_q   <= fst_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign o_tx_start  = txs_q;
  assign o_tx_data   = txd_q;
  assign o_fpu_op    = op_q;
  assign o_fpu_a     = a_q;
  assign o_fpu_b     = b_q;
  assign o_fpu_start = fst_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule
